// File: rtl/voltage_sampler.sv
// Periodic ADC0831-style serial conversion feeding the brownout detector's sample bus.
// Optional VOLTAGE_SAMPLER_AVG2_EN: output is the two-sample running average.
module voltage_sampler #(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       adc_dout,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [7:0] vol_out,
    output logic       bod_strobe,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [15:0] PER_LAST   = 16'(SAMPLE_PERIOD - 1);
    localparam logic [4:0]  PHASE_LAST = 5'd17;    // 9 sclk periods = 18 half phases

    state_t      r_state, w_state_nxt;
    logic [15:0] r_per_cnt;
    logic        r_pending;
    logic [7:0]  r_div_cnt;
    logic [4:0]  r_phase;
    logic [7:0]  r_shift;
    logic        w_tick, w_div_last, w_start, w_abort, w_done;
    logic [7:0]  w_sample;

    assign w_tick     = en && (r_per_cnt == 16'd0);
    assign w_div_last = (r_div_cnt == DIV_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_abort     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_pending && en) begin
                    w_start     = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                if (!en)             w_abort     = 1'b1;
                else if (w_div_last) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (!en)                                      w_abort     = 1'b1;
                else if (w_div_last && r_phase == PHASE_LAST) w_state_nxt = DONE;
            end
            DONE: begin
                if (!en) begin
                    w_abort = 1'b1;
                end else begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Period tick and request bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_per_cnt <= 16'd0;
            r_pending <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (!en)                      r_per_cnt <= 16'd0;
            else if (r_per_cnt == PER_LAST) r_per_cnt <= 16'd0;
            else                          r_per_cnt <= r_per_cnt + 16'd1;
            // NOTE: a tick landing on the start cycle must survive, so set has priority over clear.
            if (w_tick)                  r_pending <= 1'b1;
            else if (w_start || w_abort) r_pending <= 1'b0;
            if (w_tick && r_pending) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adc_cs_n   <= 1'b1;
            adc_sclk   <= 1'b0;
            busy       <= 1'b0;
            bod_strobe <= 1'b0;
            vol_out    <= 8'd0;
            r_div_cnt  <= 8'd0;
            r_phase    <= 5'd0;
            r_shift    <= 8'd0;
        end else begin
            bod_strobe <= 1'b0;
            if (w_start) begin
                adc_cs_n  <= 1'b0;
                busy      <= 1'b1;
                r_div_cnt <= 8'd0;
            end else if (w_abort) begin
                adc_cs_n <= 1'b1;
                adc_sclk <= 1'b0;
                busy     <= 1'b0;
            end else if (r_state == SETUP) begin
                if (w_div_last) begin
                    r_div_cnt <= 8'd0;
                    r_phase   <= 5'd0;
                    adc_sclk  <= 1'b1;
                    r_shift   <= {r_shift[6:0], adc_dout};
                end else begin
                    r_div_cnt <= r_div_cnt + 8'd1;
                end
            end else if (r_state == SHIFT) begin
                if (w_div_last) begin
                    r_div_cnt <= 8'd0;
                    if (r_phase != PHASE_LAST) begin
                        r_phase  <= r_phase + 5'd1;
                        adc_sclk <= ~adc_sclk;
                        // Nine samples into eight bits: the null bit falls off the top.
                        if (!adc_sclk) r_shift <= {r_shift[6:0], adc_dout};
                    end
                end else begin
                    r_div_cnt <= r_div_cnt + 8'd1;
                end
            end else if (w_done) begin
                adc_cs_n   <= 1'b1;
                adc_sclk   <= 1'b0;
                busy       <= 1'b0;
                bod_strobe <= 1'b1;
                vol_out    <= w_sample;
            end
        end
    end

`ifdef VOLTAGE_SAMPLER_AVG2_EN
    logic [7:0] r_hist;
    logic       r_hist_vld;
    logic [8:0] w_sum;

    assign w_sum    = {1'b0, r_hist} + {1'b0, r_shift};
    assign w_sample = r_hist_vld ? w_sum[8:1] : r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist     <= 8'd0;
            r_hist_vld <= 1'b0;
        end else if (w_done) begin
            r_hist     <= r_shift;
            r_hist_vld <= 1'b1;
        end else if (w_abort) begin
            r_hist_vld <= 1'b0;
        end
    end
`else
    assign w_sample = r_shift;
`endif

endmodule

// File: tb/tb_voltage_sampler.sv
// Directed bench: two sampler instances (long and short period) driven by simple ADC models.
module tb_voltage_sampler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_a = 1'b0, en_b = 1'b0;
    wire        dout_a, dout_b;
    logic       cs_a, sclk_a, strobe_a, busy_a, ovr_a;
    logic       cs_b, sclk_b, strobe_b, busy_b, ovr_b;
    logic [7:0] vol_a, vol_b;
    logic [8:0] frame_a, frame_b;
    int         idx_a = 8, idx_b = 8;
    int         checks = 0, failures = 0;
    int         cyc = 0;

`ifdef VOLTAGE_SAMPLER_AVG2_EN
    localparam logic [7:0] EXP_CONV2 = 8'h70;   // (0xA5 + 0x3C) >> 1
    localparam logic [7:0] EXP_CONV5 = 8'h60;   // (0x80 + 0x40) >> 1
`else
    localparam logic [7:0] EXP_CONV2 = 8'h3C;
    localparam logic [7:0] EXP_CONV5 = 8'h40;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    voltage_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(100)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en_a), .adc_dout(dout_a),
        .adc_cs_n(cs_a), .adc_sclk(sclk_a), .vol_out(vol_a),
        .bod_strobe(strobe_a), .busy(busy_a), .overrun(ovr_a)
    );

    voltage_sampler #(.CLK_DIV(2), .SAMPLE_PERIOD(20)) u_dut_ovr (
        .clk(clk), .rst_n(rst_n), .en(en_b), .adc_dout(dout_b),
        .adc_cs_n(cs_b), .adc_sclk(sclk_b), .vol_out(vol_b),
        .bod_strobe(strobe_b), .busy(busy_b), .overrun(ovr_b)
    );

    // ADC models: frame bit 8 is the null bit, next bit after every sclk fall.
    always @(posedge cs_a or negedge sclk_a) begin
        if (cs_a)           idx_a = 8;
        else if (idx_a > 0) idx_a = idx_a - 1;
    end
    always @(posedge cs_b or negedge sclk_b) begin
        if (cs_b)           idx_b = 8;
        else if (idx_b > 0) idx_b = idx_b - 1;
    end
    assign dout_a = frame_a[idx_a];
    assign dout_b = frame_b[idx_b];

    // Monitor for instance A, sampled on the falling clk edge.
    int         fall_a = 0, last_fall_a = 0, prev_fall_a = 0, rises_a = 0, low_len_a = 0;
    int         strobes_a = 0, strobe_cyc_a = 0, adj_a = 0, idle_clk_a = 0, vol_jump_a = 0;
    logic [7:0] strobe_vol_a = 8'd0, prev_vol_a = 8'd0;
    logic       p_cs_a = 1'b1, p_sclk_a = 1'b0, p_str_a = 1'b0;

    always @(negedge clk) begin
        if (p_cs_a && !cs_a) begin
            prev_fall_a = last_fall_a;
            last_fall_a = cyc;
            rises_a     = 0;
            fall_a++;
        end
        if (!p_cs_a && cs_a) low_len_a = cyc - last_fall_a;
        if (!p_sclk_a && sclk_a) rises_a++;
        if (cs_a && sclk_a) idle_clk_a++;
        if (strobe_a) begin
            strobes_a++;
            strobe_cyc_a = cyc;
            strobe_vol_a = vol_a;
            if (p_str_a) adj_a++;
        end else if (rst_n && vol_a !== prev_vol_a) begin
            vol_jump_a++;
        end
        p_cs_a = cs_a; p_sclk_a = sclk_a; p_str_a = strobe_a; prev_vol_a = vol_a;
    end

    // Monitor for instance B.
    int         falls_b = 0, rise_cyc_b = 0, gap_b = 0, strobes_b = 0, adj_b = 0, idle_clk_b = 0;
    logic [7:0] strobe_vol_b = 8'd0;
    logic       p_cs_b = 1'b1, p_str_b = 1'b0;

    always @(negedge clk) begin
        if (!p_cs_b && cs_b) rise_cyc_b = cyc;
        if (p_cs_b && !cs_b) begin
            if (falls_b > 0) gap_b = cyc - rise_cyc_b;
            falls_b++;
        end
        if (cs_b && sclk_b) idle_clk_b++;
        if (strobe_b) begin
            strobes_b++;
            strobe_vol_b = vol_b;
            if (p_str_b) adj_b++;
        end
        p_cs_b = cs_b; p_str_b = strobe_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_strobes_a(input int want, input int budget, input string tag);
        int n = 0;
        while (strobes_a < want && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(strobes_a >= want), 32'd1);
    endtask

    initial begin
        int n;
        frame_a = {1'b0, 8'hA5};
        frame_b = {1'b0, 8'h5A};
        repeat (3) step();

        check("rst_cs_n",   cs_a,     1'b1);
        check("rst_sclk",   sclk_a,   1'b0);
        check("rst_vol",    vol_a,    8'h00);
        check("rst_strobe", strobe_a, 1'b0);
        check("rst_busy",   busy_a,   1'b0);
        check("rst_ovr",    ovr_a,    1'b0);

        rst_n = 1'b1;
        step();
        en_a = 1'b1;

        wait_strobes_a(1, 200, "conv1_done");
        check("conv1_latency",  strobe_cyc_a - last_fall_a, 39);
        check("conv1_cs_low",   low_len_a, 39);
        check("conv1_rises",    rises_a, 9);
        check("conv1_vol",      strobe_vol_a, 8'hA5);
        step();
        check("conv1_busy_off", busy_a, 1'b0);

        frame_a = {1'b1, 8'h3C};
        wait_strobes_a(2, 200, "conv2_done");
        check("conv_period", last_fall_a - prev_fall_a, 100);
        check("conv2_vol",   strobe_vol_a, EXP_CONV2);

        frame_a = {1'b0, 8'hFF};
        n = 0;
        while (!(fall_a == 3 && rises_a == 5) && n < 300) begin
            step();
            n++;
        end
        check("abort_reach", 32'(fall_a == 3 && rises_a == 5), 32'd1);
        check("abort_busy_pre", busy_a, 1'b1);
        en_a = 1'b0;
        step();
        check("abort_cs_n", cs_a,   1'b1);
        check("abort_sclk", sclk_a, 1'b0);
        check("abort_busy", busy_a, 1'b0);
        repeat (80) step();
        check("abort_no_strobe", strobes_a, 2);
        check("abort_vol_kept",  vol_a, EXP_CONV2);

        frame_a = {1'b0, 8'h80};
        en_a = 1'b1;
        wait_strobes_a(3, 200, "conv4_done");
        check("conv4_vol", strobe_vol_a, 8'h80);
        frame_a = {1'b0, 8'h40};
        wait_strobes_a(4, 200, "conv5_done");
        check("conv5_vol", strobe_vol_a, EXP_CONV5);

        n = 0;
        while (!(fall_a == 6 && rises_a >= 3) && n < 300) begin
            step();
            n++;
        end
        check("rst_mid_reach", 32'(fall_a == 6 && rises_a >= 3), 32'd1);
        check("rst_mid_busy_pre", busy_a, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_cs_n",   cs_a,     1'b1);
        check("arst_sclk",   sclk_a,   1'b0);
        check("arst_vol",    vol_a,    8'h00);
        check("arst_strobe", strobe_a, 1'b0);
        check("arst_busy",   busy_a,   1'b0);
        en_a = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        check("a_adjacent_strobes", adj_a, 0);
        check("a_sclk_while_idle",  idle_clk_a, 0);
        check("a_vol_unstable",     vol_jump_a, 0);

        en_b = 1'b1;
        n = 0;
        while (falls_b < 1 && n < 50) begin
            step();
            n++;
        end
        check("b_first_start", 32'(falls_b >= 1), 32'd1);
        check("b_ovr_initial", ovr_b, 1'b0);
        n = 0;
        while (strobes_b < 3 && n < 300) begin
            step();
            n++;
        end
        check("b_three_strobes",   32'(strobes_b >= 3), 32'd1);
        check("b_cs_gap",          gap_b, 1);
        check("b_overrun",         ovr_b, 1'b1);
        check("b_adjacent",        adj_b, 0);
        check("b_vol",             strobe_vol_b, 8'h5A);
        check("b_sclk_while_idle", idle_clk_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/voltage_sampler.md
Name: voltage_sampler

Overview:
- Source end of the 8-bit voltage sample interface consumed by the brownout rate detector.
- Periodically runs an 8-bit serial ADC conversion (ADC0831-style: chip select, serial clock, serial data).
- Presents each result on an 8-bit sample bus with a one-cycle valid strobe.
- The strobe drives the detector's BOD_in and the bus drives its in_bus, so the detector evaluates exactly once per fresh sample.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period (legal range 1..255)
SAMPLE_PERIOD, 1000, clk cycles between conversion start requests (legal range 2..65535)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  sampling enable
adc_dout  input  1  serial data from ADC; changes after sclk falling edge
adc_cs_n  output  1  ADC chip select, active low
adc_sclk  output  1  ADC serial clock
vol_out  output  8  last completed sample; feeds detector in_bus
bod_strobe  output  1  one-cycle pulse, vol_out updated this cycle; feeds detector BOD_in
busy  output  1  high from cs_n fall through DONE cycle
overrun  output  1  sticky; set when a period tick arrives while a request is already pending

Behaviour:
- Reset (async, rst_n=0): adc_cs_n=1, adc_sclk=0, vol_out=0, bod_strobe=0, busy=0, overrun=0, state=IDLE, period counter=0, pending=0.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 while en=1, then wraps to 0.
  - Held at 0 while en=0.
  - Tick = counter==0 with en=1; tick sets pending.
  - If pending is already 1 at a tick, overrun is set. overrun clears only on reset.
- States: IDLE, SETUP, SHIFT, DONE.
- IDLE: cs_n=1, sclk=0. If pending and en, clear pending, drop cs_n, set busy, go to SETUP.
- SETUP: hold cs_n low for CLK_DIV cycles, then go to SHIFT.
- SHIFT: exactly 9 sclk periods, each CLK_DIV cycles high then CLK_DIV cycles low.
  - adc_dout is sampled on the clk edge where sclk goes 0->1.
  - Sample 1 is the ADC null/start bit and is discarded.
  - Samples 2..9 are shifted in MSB-first.
  - After the 9th low phase, go to DONE.
- DONE (1 cycle): cs_n=1, sclk=0, vol_out<=shift register, bod_strobe=1, busy=0 next cycle, go to IDLE.
- Latency: cs_n fall to bod_strobe high = 19*CLK_DIV+1 clk cycles (77 at CLK_DIV=4).
- bod_strobe is never high on two consecutive cycles.
- vol_out is stable between strobes.
- A tick during SETUP/SHIFT/DONE sets pending. The next conversion starts in the first IDLE cycle after DONE; there is no overlap between conversions.
- en deasserted mid-conversion: abort on the next clk, cs_n=1, sclk=0, go to IDLE, no strobe, vol_out unchanged, pending cleared, busy=0.
- en and tick in the same cycle as DONE: strobe still issues; pending is honoured from IDLE.
- sclk idles low whenever cs_n is high.

Optional Feature:
- Macro: VOLTAGE_SAMPLER_AVG2_EN.
- Defined: vol_out = (previous raw sample + new raw sample) >> 1, computed 9-bit, truncated, updated at DONE.
  - The first sample after reset or abort is output unaveraged and seeds the history.
  - Strobe timing is unchanged.
- Undefined: vol_out = raw sample; no history register.

Test Plan:
- CLK_DIV=2, SAMPLE_PERIOD=100, ADC model returns 0xA5 -> cs_n low 39 cycles; 9 sclk rising edges; bod_strobe 1 cycle at cs_n-fall+39; vol_out=0xA5; next cs_n fall 100 cycles after previous.
- ADC model drives null bit 1 then 0x3C -> vol_out=0x3C (null bit discarded, MSB-first).
- Drop en at 5th sclk rising edge -> cs_n=1 and sclk=0 next cycle, no strobe, vol_out keeps prior 0x3C, busy=0.
- SAMPLE_PERIOD=20, CLK_DIV=2 (conversion longer than period) -> back-to-back conversions, one cycle of cs_n high between them, overrun=1, strobes never adjacent.
- rst_n pulsed low mid-SHIFT -> outputs at reset values immediately, asynchronously, without waiting for clk.
- With VOLTAGE_SAMPLER_AVG2_EN, samples 0x80 then 0x40 -> vol_out 0x80 then 0x60. Without the macro -> 0x80 then 0x40.
